// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer: selects exception, mret or interrupt,
// updates the trap CSRs and mstatus, and holds a fetch redirect until accepted.
module trap_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic            time_compare,
    input  logic            ext_irq,
    input  logic            sw_irq,
    input  logic            done,
    input  logic [XLEN-1:0] commit_next_pc,
    input  logic            exc_valid,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_badaddr,
    input  logic            mret,
    output logic [XLEN-1:0] mip,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mbadaddr,
    output logic            mstatus_we,
    output logic [XLEN-1:0] mstatus_wdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy
);

    typedef enum logic [0:0] {IDLE, REDIRECT} state_t;

    state_t          state, state_next;
    logic            take_exc, take_mret, take_irq;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] mip_next;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] vec_off;
    logic [XLEN-1:0] irq_target;

    always_comb begin
        mip_next     = '0;
        mip_next[3]  = sw_irq;
        mip_next[7]  = time_compare;
        mip_next[11] = ext_irq;
    end

    assign pend       = mip & mie;
    assign tvec_base  = {mtvec[XLEN-1:2], 2'b00};
    assign vec_off    = {{(XLEN-6){1'b0}}, irq_code, 2'b00};
    assign irq_target = (mtvec[1:0] == 2'b01) ? tvec_base + vec_off : tvec_base;

    always_ff @(posedge clk) begin
        if (resetn) state <= IDLE;
        else        state <= state_next;
    end

    // Exception beats mret beats interrupt; interrupts need a commit boundary.
    always_comb begin
        state_next = state;
        take_exc   = 1'b0;
        take_mret  = 1'b0;
        take_irq   = 1'b0;
        irq_code   = 4'd7;
        if (pend[11])     irq_code = 4'd11;
        else if (pend[3]) irq_code = 4'd3;
        case (state)
            IDLE: begin
                if (exc_valid)                              take_exc  = 1'b1;
                else if (mret)                              take_mret = 1'b1;
                else if (mstatus[3] && (pend != '0) && done) take_irq  = 1'b1;
                if (take_exc || take_mret || take_irq) state_next = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            mip           <= '0;
            mcause        <= '0;
            mepc          <= RESET_PC;
            mbadaddr      <= '0;
            mstatus_we    <= 1'b0;
            mstatus_wdata <= '0;
            redirect_pc   <= RESET_PC;
        end else begin
            mip        <= mip_next;
            mstatus_we <= take_exc || take_mret || take_irq;
            if (take_exc) begin
                mcause      <= {1'b0, {(XLEN-5){1'b0}}, exc_code};
                mepc        <= exc_pc;
                mbadaddr    <= exc_badaddr;
                redirect_pc <= tvec_base;
            end else if (take_irq) begin
                mcause      <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
                mepc        <= commit_next_pc;
                redirect_pc <= irq_target;
            end else if (take_mret) begin
                redirect_pc <= mepc;
            end
            if (take_exc || take_irq) begin
                mstatus_wdata    <= mstatus;
                mstatus_wdata[7] <= mstatus[3];
                mstatus_wdata[3] <= 1'b0;
            end else if (take_mret) begin
                mstatus_wdata    <= mstatus;
                mstatus_wdata[3] <= mstatus[7];
                mstatus_wdata[7] <= 1'b1;
            end
        end
    end

    assign redirect_valid = (state == REDIRECT);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl; trap results are queued at stimulus time and
// checked when the redirect appears.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] mstatus, mie, mtvec, commit_next_pc, exc_pc, exc_badaddr;
    logic        time_compare, ext_irq, sw_irq, done, exc_valid, mret, redirect_ready;
    logic [3:0]  exc_code;
    logic [31:0] mip, mcause, mepc, mbadaddr, mstatus_wdata, redirect_pc;
    logic        mstatus_we, redirect_valid, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mbadaddr;
        logic [31:0] wdata;
        logic [31:0] rpc;
    } exp_t;
    exp_t sb[$];

    trap_ctrl #(.XLEN(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .resetn(resetn), .mstatus(mstatus), .mie(mie), .mtvec(mtvec),
        .time_compare(time_compare), .ext_irq(ext_irq), .sw_irq(sw_irq),
        .done(done), .commit_next_pc(commit_next_pc), .exc_valid(exc_valid),
        .exc_code(exc_code), .exc_pc(exc_pc), .exc_badaddr(exc_badaddr),
        .mret(mret), .mip(mip), .mcause(mcause), .mepc(mepc), .mbadaddr(mbadaddr),
        .mstatus_we(mstatus_we), .mstatus_wdata(mstatus_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] c, input logic [31:0] e, input logic [31:0] b,
                        input logic [31:0] w, input logic [31:0] r);
        exp_t x;
        x.mcause = c; x.mepc = e; x.mbadaddr = b; x.wdata = w; x.rpc = r;
        sb.push_back(x);
    endtask

    // Clocks the triggering edge, waits (bounded) for the redirect, then compares.
    task automatic expect_trap(input string tag);
        exp_t x;
        int   n = 0;
        step();
        chk({tag, "_we"}, {31'b0, mstatus_we}, 32'd1);
        while (redirect_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk({tag, "_rv"}, {31'b0, redirect_valid}, 32'd1);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            chk({tag, "_mcause"}, mcause, x.mcause);
            chk({tag, "_mepc"}, mepc, x.mepc);
            chk({tag, "_mbadaddr"}, mbadaddr, x.mbadaddr);
            chk({tag, "_wdata"}, mstatus_wdata, x.wdata);
            chk({tag, "_rpc"}, redirect_pc, x.rpc);
        end
    endtask

    initial begin
        resetn = 1'b1; mstatus = '0; mie = '0; mtvec = '0; commit_next_pc = '0;
        exc_pc = '0; exc_badaddr = '0; exc_code = '0; time_compare = 1'b0;
        ext_irq = 1'b0; sw_irq = 1'b0; done = 1'b0; exc_valid = 1'b0;
        mret = 1'b0; redirect_ready = 1'b0;

        // Reset
        step(); step();
        resetn = 1'b0;
        chk("rst_mip", mip, 32'h0);
        chk("rst_mcause", mcause, 32'h0);
        chk("rst_mbadaddr", mbadaddr, 32'h0);
        chk("rst_mepc", mepc, 32'h100);
        chk("rst_rpc", redirect_pc, 32'h100);
        chk("rst_we", {31'b0, mstatus_we}, 32'd0);
        chk("rst_wdata", mstatus_wdata, 32'h0);
        chk("rst_rv", {31'b0, redirect_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        // Exception, held redirect for two cycles
        exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h40; exc_badaddr = 32'hDEAD;
        mtvec = 32'h200; mstatus = 32'h8;
        push(32'h2, 32'h40, 32'hDEAD, 32'h80, 32'h200);
        expect_trap("exc");
        exc_valid = 1'b0;
        step();
        chk("exc_we_pulse", {31'b0, mstatus_we}, 32'd0);
        chk("exc_hold_rv", {31'b0, redirect_valid}, 32'd1);
        chk("exc_hold_rpc", redirect_pc, 32'h200);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("exc_done_busy", {31'b0, busy}, 32'd0);
        chk("exc_done_rv", {31'b0, redirect_valid}, 32'd0);

        // Vectored timer interrupt, redirect accepted on its first cycle
        time_compare = 1'b1; mie = 32'h80; mstatus = 32'h8; mtvec = 32'h301;
        step();
        chk("mip_timer", mip, 32'h80);
        chk("no_irq_wo_done", {31'b0, busy}, 32'd0);
        done = 1'b1; commit_next_pc = 32'h84;
        push(32'h8000_0007, 32'h84, 32'hDEAD, 32'h80, 32'h31C);
        expect_trap("mti");
        done = 1'b0; redirect_ready = 1'b1; time_compare = 1'b0;
        step();
        redirect_ready = 1'b0;
        chk("mti_one_cycle", {31'b0, busy}, 32'd0);

        // Priority: MEI over MSI and MTI
        ext_irq = 1'b1; sw_irq = 1'b1; time_compare = 1'b1; mie = 32'h888;
        step();
        chk("mip_all", mip, 32'h888);
        done = 1'b1; commit_next_pc = 32'h84;
        push(32'h8000_000B, 32'h84, 32'hDEAD, 32'h80, 32'h32C);
        expect_trap("mei");
        done = 1'b0; redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;

        // Masked by mstatus.MIE
        mstatus = 32'h0; done = 1'b1;
        step(); step();
        chk("mask_busy", {31'b0, busy}, 32'd0);
        chk("mask_we", {31'b0, mstatus_we}, 32'd0);
        done = 1'b0; ext_irq = 1'b0; sw_irq = 1'b0; time_compare = 1'b0;

        // mret
        mstatus = 32'h80; mret = 1'b1;
        push(32'h8000_000B, 32'h84, 32'hDEAD, 32'h88, 32'h84);
        expect_trap("mret");
        mret = 1'b0; redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;

        // Exception and mret together; held redirect ignores new exceptions
        mstatus = 32'h88; mtvec = 32'h200; exc_valid = 1'b1; mret = 1'b1;
        exc_code = 4'd5; exc_pc = 32'h60; exc_badaddr = 32'hBEEF;
        push(32'h5, 32'h60, 32'hBEEF, 32'h80, 32'h200);
        expect_trap("excmret");
        mret = 1'b0; exc_code = 4'd9; exc_pc = 32'h70; exc_badaddr = 32'h1234;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_rv", {31'b0, redirect_valid}, 32'd1);
            chk("hold_rpc", redirect_pc, 32'h200);
            chk("hold_mcause", mcause, 32'h5);
        end
        exc_valid = 1'b0;

        // Reset during redirect
        resetn = 1'b1;
        step();
        resetn = 1'b0;
        chk("rst_mid_rv", {31'b0, redirect_valid}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_mepc", mepc, 32'h100);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap and interrupt sequencer. It sits directly upstream of the CSR file and feeds its mip, mcause, mbadaddr and mepc inputs. It consumes mstatus, mie, mtvec and time_compare from the CSR file, plus exception and commit information from the core. It decides when a trap or mret happens, updates the trap CSRs and mstatus, and issues a PC redirect to fetch.

Parameters:
XLEN, 32, datapath and CSR width
RESET_PC, 32'h0000_0000, reset value for mepc and redirect_pc

Ports:
clk  in  1  system clock
resetn  in  1  reset; one clock; reset is synchronous and active-high
mstatus  in  XLEN  from CSR file; bit3 MIE, bit7 MPIE
mie  in  XLEN  from CSR file; bit3 MSIE, bit7 MTIE, bit11 MEIE
mtvec  in  XLEN  from CSR file; [1:0] mode, [XLEN-1:2] base
time_compare  in  1  timer-expired level from CSR file
ext_irq  in  1  external interrupt level
sw_irq  in  1  software interrupt level
done  in  1  instruction-commit pulse
commit_next_pc  in  XLEN  PC of the next instruction, valid with done
exc_valid  in  1  synchronous exception request from core
exc_code  in  4  exception cause code
exc_pc  in  XLEN  PC of the faulting instruction
exc_badaddr  in  XLEN  faulting address or instruction
mret  in  1  mret committing this cycle
mip  out  XLEN  to CSR file
mcause  out  XLEN  to CSR file
mepc  out  XLEN  to CSR file
mbadaddr  out  XLEN  to CSR file
mstatus_we  out  1  one-cycle write strobe for mstatus in the CSR file
mstatus_wdata  out  XLEN  new mstatus value
redirect_valid  out  1  fetch redirect request
redirect_pc  out  XLEN  redirect target
redirect_ready  in  1  fetch accepts redirect
busy  out  1  high when not IDLE; core stalls commit

Behaviour:
- Reset, sampled at a clk edge while resetn=1:
  - mip, mcause, mbadaddr, mstatus_we, mstatus_wdata, redirect_valid = 0.
  - mepc and redirect_pc = RESET_PC.
  - State goes to IDLE and busy = 0.
- Reset mid-redirect drops redirect_valid on the next edge.
- mip is registered every cycle, independent of state: bit3 = sw_irq, bit7 = time_compare, bit11 = ext_irq, other bits 0. One cycle of latency.
- pend = mip & mie. An interrupt is eligible only when mstatus[3]=1, pend≠0, done=1 and state is IDLE.
- Decision is made in IDLE with this priority:
  1. exc_valid
  2. mret
  3. interrupt, in order MEI (11) > MSI (3) > MTI (7)
- exc_valid and mret in the same cycle: the exception wins and mret is ignored.
- Exception taken in cycle N; at edge N+1:
  - mcause = {1'b0, 27'b0, exc_code}.
  - mepc = exc_pc.
  - mbadaddr = exc_badaddr.
  - redirect_pc = {mtvec[XLEN-1:2], 2'b00}.
- Interrupt taken in cycle N; at edge N+1:
  - mcause = {1'b1, code}.
  - mepc = commit_next_pc.
  - mbadaddr is unchanged.
  - If mtvec[1:0] = 1 (vectored), redirect_pc = base + 4*code; otherwise redirect_pc = base.
  - Addition wraps at XLEN.
- Any trap, at edge N+1:
  - mstatus_we = 1 for exactly one cycle.
  - mstatus_wdata = mstatus with bit7 = old bit3 and bit3 = 0.
  - Other mstatus bits pass through unchanged.
- mret in cycle N, at edge N+1:
  - mstatus_wdata = mstatus with bit3 = old bit7 and bit7 = 1.
  - mstatus_we pulses for one cycle.
  - redirect_pc = mepc.
  - mcause, mepc and mbadaddr are unchanged.
- FSM states and transitions:
  - IDLE → REDIRECT on any trap or mret.
  - REDIRECT: redirect_valid = 1 and redirect_pc held stable; busy = 1. Stays until redirect_ready = 1, then returns to IDLE on that edge.
  - redirect_ready may already be high on the first REDIRECT cycle; the redirect then lasts one cycle.
- exc_valid, mret and interrupts arriving while in REDIRECT are ignored. The core guarantees no commit while busy, and interrupts re-evaluate at the next eligible done.
- Level-sensitive interrupts are not latched. If the source drops before an eligible done, no trap is taken.

Test Plan:
- Reset: resetn=1 for 2 cycles with RESET_PC=32'h100 → all outputs 0, mepc = redirect_pc = 32'h100, busy = 0.
- Exception: exc_valid=1, exc_code=2, exc_pc=32'h40, exc_badaddr=32'hDEAD, mtvec=32'h200, mstatus=32'h8 → next cycle: mcause=2, mepc=32'h40, mbadaddr=32'hDEAD, mstatus_wdata=32'h80 with one-cycle we, redirect_pc=32'h200 held until redirect_ready.
- Vectored timer interrupt: time_compare=1, mie=32'h80, mstatus=32'h8, mtvec=32'h301, done=1, commit_next_pc=32'h84 → mcause=32'h8000_0007, mepc=32'h84, redirect_pc=32'h31C.
- Priority and masking:
  - ext_irq=sw_irq=time_compare=1, mie=32'h888 → mcause=32'h8000_000B.
  - Repeat with mstatus[3]=0 → no trap, busy stays 0.
- mret after trap: mstatus=32'h80, mepc=32'h84, mret=1 → mstatus_wdata=32'h88, redirect_pc=32'h84.
- Simultaneous exc_valid and mret → exception path only. Holding redirect_ready=0 for 5 cycles keeps redirect_valid=1 and ignores a new exc_valid. A resetn pulse during REDIRECT clears redirect_valid on the next edge.
